scene_cmd_writer: RTL and testbench

SCENE_CMD_WRITER -- requirements
Module: scene_cmd_writer

---
 rtl/scene_cmd_writer_pkg.sv | 19 +
 rtl/scene_cmd_writer_cmd_fifo.sv | 54 +++++
 rtl/scene_cmd_writer.sv | 138 +++++++++++++
 tb/tb_scene_cmd_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scene_cmd_writer_pkg.sv
// Shared definitions for the scene command writer: bus response codes,
// FSM state encoding and the retry limit used when WRITE_RETRY_EN is defined.
package scene_cmd_writer_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Additional attempts allowed for a word that receives SLVERR.
  localparam int unsigned MAX_RETRIES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/scene_cmd_writer_cmd_fifo.sv
// Command word FIFO; DEPTH must be a power of two (>= 2) so pointers wrap
// naturally. ready is forced low while rst_n is asserted.
module cmd_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push,
  output logic                  ready,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_push;
  logic                  do_pop;

  // ready comes straight from occupancy, so a pop in the same cycle cannot
  // open a slot for a push while full.
  assign ready   = rst_n && (count != (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scene_cmd_writer.sv
// Drains queued command words as single-beat AXI-Lite writes to a fixed
// address. Optional macro WRITE_RETRY_EN reissues a word on SLVERR.
module scene_cmd_writer #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          FIFO_DEPTH  = 4,
  parameter int unsigned TARGET_ADDR = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [ADDR_WIDTH-1:0]   oAWADDR,
  output logic [2:0]              oAWPROT,
  output logic                    oAWVALID,
  input  logic                    oAWREADY,
  output logic [DATA_WIDTH-1:0]   oWDATA,
  output logic [DATA_WIDTH/8-1:0] oWSTRB,
  output logic                    oWVALID,
  input  logic                    oWREADY,
  input  logic [1:0]              oBRESP,
  input  logic                    oBVALID,
  output logic                    oBREADY,
  output logic                    busy,
  output logic [1:0]              last_resp,
  output logic [7:0]              err_count,
  output logic                    done
);

  import scene_cmd_writer_pkg::*;

  state_t                state;
  state_t                state_next;
  logic                  pop;
  logic                  bready;
  logic                  b_hs;
  logic                  retry;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  aw_pend;
  logic                  w_pend;
  logic                  done_q;
  logic [1:0]            last_resp_q;
  logic [7:0]            err_q;
`ifdef WRITE_RETRY_EN
  logic [1:0]            attempt;
`endif

  cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .push_data (cmd_data),
    .push      (cmd_valid),
    .ready     (cmd_ready),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = ADDR;
      ADDR:    if ((!aw_pend || oAWREADY) && (!w_pend || oWREADY)) state_next = RESP;
      RESP:    if (b_hs) state_next = retry ? ADDR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The done cycle is spent in IDLE without popping, giving the 4-cycle word.
  always_comb begin
    pop    = (state == IDLE) && !fifo_empty && !done_q;
    bready = (state == RESP);
    b_hs   = bready && oBVALID;
    retry  = 1'b0;
`ifdef WRITE_RETRY_EN
    retry  = b_hs && (oBRESP == RESP_SLVERR) && (attempt != 2'(MAX_RETRIES));
`endif
  end

  always_ff @(posedge ACLK) begin
    if (pop) data_q <= fifo_head;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      done_q      <= 1'b0;
      last_resp_q <= RESP_OKAY;
      err_q       <= '0;
    end else begin
      done_q <= b_hs && !retry;
      if (pop || retry) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else begin
        if (oAWREADY) aw_pend <= 1'b0;
        if (oWREADY)  w_pend  <= 1'b0;
      end
      if (b_hs) begin
        last_resp_q <= oBRESP;
        if (oBRESP != RESP_OKAY && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
    end
  end

`ifdef WRITE_RETRY_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)   attempt <= '0;
    else if (pop)   attempt <= '0;
    else if (retry) attempt <= attempt + 2'd1;
  end
`endif

  assign oAWADDR   = ADDR_WIDTH'(TARGET_ADDR);
  assign oAWPROT   = 3'b000;
  assign oAWVALID  = aw_pend;
  assign oWDATA    = data_q;
  assign oWSTRB    = '1;
  assign oWVALID   = w_pend;
  assign oBREADY   = bready;
  assign busy      = !fifo_empty || (state != IDLE);
  assign last_resp = last_resp_q;
  assign err_count = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_scene_cmd_writer.sv
// Directed bench for scene_cmd_writer: single write, AW stall, FIFO full,
// error responses with saturation, and reset mid-transaction.
module tb_scene_cmd_writer;

  logic        ACLK      = 1'b0;
  logic        ARESETn   = 1'b0;
  logic [31:0] cmd_data  = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready   = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready    = 1'b0;
  logic [1:0]  bresp     = 2'b00;
  logic        bvalid    = 1'b0;
  logic        bready;
  logic        busy;
  logic [1:0]  last_resp;
  logic [7:0]  err_count;
  logic        done;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          aw_cnt   = 0;
  int          w_cnt    = 0;
  int          done_cnt = 0;
  int          addr_bad = 0;
  logic [31:0] wq [$];

`ifdef WRITE_RETRY_EN
  localparam int EXP_ATT = 3;
`else
  localparam int EXP_ATT = 1;
`endif

  always #5 ACLK = ~ACLK;

  scene_cmd_writer dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .oAWADDR   (awaddr),
    .oAWPROT   (awprot),
    .oAWVALID  (awvalid),
    .oAWREADY  (awready),
    .oWDATA    (wdata),
    .oWSTRB    (wstrb),
    .oWVALID   (wvalid),
    .oWREADY   (wready),
    .oBRESP    (bresp),
    .oBVALID   (bvalid),
    .oBREADY   (bready),
    .busy      (busy),
    .last_resp (last_resp),
    .err_count (err_count),
    .done      (done)
  );

  // Bus monitor: counts handshakes and records write data in issue order.
  always @(posedge ACLK) begin
    if (ARESETn) begin
      if (awvalid && awready) begin
        aw_cnt <= aw_cnt + 1;
        if (awaddr != 32'd1) addr_bad <= addr_bad + 1;
      end
      if (wvalid && wready) begin
        w_cnt <= w_cnt + 1;
        wq.push_back(wdata);
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      step(1);
      n++;
    end
    if (n == 200) check_eq("push_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_data  = w;
    cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0, w0, d0, aw_hi, w_hi, unstable, n;
    bit          seen;
    logic [31:0] words [5];

    // Reset state
    step(2);
    check_eq("rst_awvalid", {31'd0, awvalid}, 0);
    check_eq("rst_wvalid", {31'd0, wvalid}, 0);
    check_eq("rst_bready", {31'd0, bready}, 0);
    check_eq("rst_done", {31'd0, done}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_err", {24'd0, err_count}, 0);
    check_eq("rst_last_resp", {30'd0, last_resp}, 0);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    #2 ARESETn = 1'b1;
    #1 check_eq("ready_after_rst", {31'd0, cmd_ready}, 1);
    step(3);
    check_eq("idle_awvalid", {31'd0, awvalid}, 0);
    check_eq("idle_wvalid", {31'd0, wvalid}, 0);
    check_eq("idle_busy", {31'd0, busy}, 0);

    // Single write, always-ready OKAY slave
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    wq.delete();
    push_word(32'h0000_0A5A);
    check_eq("t1_pop_awvalid", {31'd0, awvalid}, 0);
    check_eq("t1_pop_busy", {31'd0, busy}, 1);
    step(1);
    check_eq("t1_awvalid", {31'd0, awvalid}, 1);
    check_eq("t1_wvalid", {31'd0, wvalid}, 1);
    check_eq("t1_awaddr", awaddr, 32'd1);
    check_eq("t1_wdata", wdata, 32'h0000_0A5A);
    check_eq("t1_wstrb", {28'd0, wstrb}, 32'hF);
    check_eq("t1_awprot", {29'd0, awprot}, 0);
    step(1);
    check_eq("t1_bready", {31'd0, bready}, 1);
    check_eq("t1_aw_dropped", {31'd0, awvalid}, 0);
    check_eq("t1_done_early", {31'd0, done}, 0);
    step(1);
    check_eq("t1_done", {31'd0, done}, 1);
    check_eq("t1_last_resp", {30'd0, last_resp}, 0);
    step(1);
    check_eq("t1_done_pulse", {31'd0, done}, 0);
    check_eq("t1_busy_end", {31'd0, busy}, 0);
    check_eq("t1_err", {24'd0, err_count}, 0);
    check_eq("t1_writes", wq.size(), 1);
    check_eq("t1_aw_cnt", aw_cnt, 1);

    // AWREADY held low for 3 cycles, WREADY high
    awready = 1'b0;
    a0 = aw_cnt; w0 = w_cnt;
    push_word(32'h1234_5678);
    step(1);
    aw_hi = 0; w_hi = 0; unstable = 0;
    for (int i = 0; i < 6; i++) begin
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if ((awvalid || wvalid) && wdata != 32'h1234_5678) unstable++;
      if (i == 3) awready = 1'b1;
      step(1);
    end
    step(2);
    check_eq("t2_aw_high_cycles", aw_hi, 4);
    check_eq("t2_w_high_cycles", w_hi, 1);
    check_eq("t2_wdata_stable", unstable, 0);
    check_eq("t2_aw_writes", aw_cnt - a0, 1);
    check_eq("t2_w_writes", w_cnt - w0, 1);
    check_eq("t2_wdata", wq[wq.size()-1], 32'h1234_5678);

    // Five words with the slave stalled: FIFO fills, then drains in order
    awready = 1'b0; wready = 1'b0;
    wq.delete();
    for (int k = 0; k < 5; k++) words[k] = 32'h1111_0001 + k;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t3_ready%0d", k), {31'd0, cmd_ready}, 1);
      push_word(words[k]);
    end
    check_eq("t3_full_ready", {31'd0, cmd_ready}, 0);
    check_eq("t3_full_busy", {31'd0, busy}, 1);
    d0 = done_cnt;
    awready = 1'b1; wready = 1'b1;
    seen = 1'b0; n = 0;
    while ((done_cnt - d0) < 5 && n < 100) begin
      if (done && !seen) begin
        seen = 1'b1;
        check_eq("t3_ready_done_cycle", {31'd0, cmd_ready}, 0);
        step(1);
        check_eq("t3_ready_pop_cycle", {31'd0, cmd_ready}, 0);
        step(1);
        check_eq("t3_ready_after_pop", {31'd0, cmd_ready}, 1);
      end
      step(1);
      n++;
    end
    check_eq("t3_done_count", done_cnt - d0, 5);
    check_eq("t3_write_count", wq.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < wq.size()) check_eq($sformatf("t3_order%0d", k), wq[k], words[k]);

    // SLVERR response
    step(2);
    bresp = 2'b10;
    a0 = aw_cnt; d0 = done_cnt;
    push_word(32'hDEAD_0001);
    step(40);
    check_eq("t4_attempts", aw_cnt - a0, EXP_ATT);
    check_eq("t4_done_once", done_cnt - d0, 1);
    check_eq("t4_last_resp", {30'd0, last_resp}, 32'd2);
    check_eq("t4_err", {24'd0, err_count}, EXP_ATT);
    bresp = 2'b00;
    push_word(32'hBEEF_0002);
    step(10);
    check_eq("t4_okay_last_resp", {30'd0, last_resp}, 0);
    check_eq("t4_okay_err", {24'd0, err_count}, EXP_ATT);

    // err_count saturation with DECERR responses
    bresp = 2'b11;
    for (int k = 0; k < 256; k++) push_word(32'hC000_0000 + k);
    n = 0;
    while (busy && n < 200) begin
      step(1);
      n++;
    end
    step(2);
    check_eq("t5_drained", {31'd0, busy}, 0);
    check_eq("t5_err_sat", {24'd0, err_count}, 32'd255);
    check_eq("t5_last_resp", {30'd0, last_resp}, 32'd3);

    // Reset during RESP with two words queued
    bresp = 2'b00; bvalid = 1'b0;
    a0 = aw_cnt;
    for (int k = 0; k < 3; k++) push_word(32'hAB00_0000 + k);
    n = 0;
    while (!bready && n < 20) begin
      step(1);
      n++;
    end
    check_eq("t6_in_resp", {31'd0, bready}, 1);
    #2 ARESETn = 1'b0;
    #1;
    check_eq("t6_rst_awvalid", {31'd0, awvalid}, 0);
    check_eq("t6_rst_wvalid", {31'd0, wvalid}, 0);
    check_eq("t6_rst_bready", {31'd0, bready}, 0);
    check_eq("t6_rst_busy", {31'd0, busy}, 0);
    check_eq("t6_rst_err", {24'd0, err_count}, 0);
    check_eq("t6_rst_cmd_ready", {31'd0, cmd_ready}, 0);
    step(1);
    #2 ARESETn = 1'b1;
    bvalid = 1'b1;
    step(10);
    check_eq("t6_busy_after", {31'd0, busy}, 0);
    check_eq("t6_no_write", aw_cnt - a0, 1);
    check_eq("t6_done_idle", {31'd0, done}, 0);
    check_eq("addr_all_one", addr_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
